// File: rtl/memory_arbiter.sv
// Two-requester memory arbiter: instruction fetch and data share one memory
// port with a single outstanding transaction; data has priority, bounded by a starvation counter.
module memory_arbiter #(
  parameter int ADRES_W      = 32,
  parameter int VERI_W       = 32,
  parameter int ACLIK_SINIRI = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // fetch port
  input  logic                getir_istek_i,
  input  logic [ADRES_W-1:0]  getir_adres_i,
  input  logic                getir_iptal_i,
  output logic                getir_kabul_o,
  output logic                getir_gecerli_o,
  output logic [VERI_W-1:0]   getir_veri_o,
  // data port
  input  logic                veri_istek_i,
  input  logic                veri_yaz_i,
  input  logic [ADRES_W-1:0]  veri_adres_i,
  input  logic [VERI_W-1:0]   veri_yazilan_i,
  input  logic [VERI_W/8-1:0] veri_maske_i,
  output logic                veri_kabul_o,
  output logic                veri_gecerli_o,
  output logic [VERI_W-1:0]   veri_okunan_o,
  // shared memory port
  output logic                bel_istek_o,
  output logic                bel_yaz_o,
  output logic [ADRES_W-1:0]  bel_adres_o,
  output logic [VERI_W-1:0]   bel_veri_o,
  output logic [VERI_W/8-1:0] bel_maske_o,
  input  logic                bel_hazir_i,
  input  logic                bel_gecerli_i,
  input  logic [VERI_W-1:0]   bel_veri_i
);

  localparam int MASKE_W = VERI_W / 8;
  localparam logic [1:0] SINIR = 2'(ACLIK_SINIRI);

  typedef enum logic [1:0] {BOSTA, ISTEK, YANIT} durum_t;

  durum_t               durum_reg, durum_next;
  logic                 sahip_veri_reg, sahip_veri_next;
  logic                 ilk_reg, ilk_next;
  logic                 iptal_reg, iptal_next;
  logic [1:0]           aclik_sayac_reg, aclik_sayac_next;
  logic [ADRES_W-1:0]   adres_reg, adres_next;
  logic                 yaz_reg, yaz_next;
  logic [VERI_W-1:0]    veri_reg, veri_next;
  logic [MASKE_W-1:0]   maske_reg, maske_next;
  logic                 getir_gecerli_reg, getir_gecerli_next;
  logic [VERI_W-1:0]    getir_veri_reg, getir_veri_next;
  logic                 veri_gecerli_reg, veri_gecerli_next;
  logic [VERI_W-1:0]    veri_okunan_reg, veri_okunan_next;

  logic getir_uygun;
  logic getir_oncelik;

  // A flushed fetch never competes; once data has won SINIR times in a row, fetch goes first.
  assign getir_uygun   = getir_istek_i && !getir_iptal_i;
  assign getir_oncelik = getir_uygun && (aclik_sayac_reg == SINIR);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_reg         <= BOSTA;
      sahip_veri_reg    <= 1'b0;
      ilk_reg           <= 1'b0;
      iptal_reg         <= 1'b0;
      aclik_sayac_reg   <= '0;
      adres_reg         <= '0;
      yaz_reg           <= 1'b0;
      veri_reg          <= '0;
      maske_reg         <= '0;
      getir_gecerli_reg <= 1'b0;
      getir_veri_reg    <= '0;
      veri_gecerli_reg  <= 1'b0;
      veri_okunan_reg   <= '0;
    end else begin
      durum_reg         <= durum_next;
      sahip_veri_reg    <= sahip_veri_next;
      ilk_reg           <= ilk_next;
      iptal_reg         <= iptal_next;
      aclik_sayac_reg   <= aclik_sayac_next;
      adres_reg         <= adres_next;
      yaz_reg           <= yaz_next;
      veri_reg          <= veri_next;
      maske_reg         <= maske_next;
      getir_gecerli_reg <= getir_gecerli_next;
      getir_veri_reg    <= getir_veri_next;
      veri_gecerli_reg  <= veri_gecerli_next;
      veri_okunan_reg   <= veri_okunan_next;
    end
  end

  always_comb begin
    durum_next         = durum_reg;
    sahip_veri_next    = sahip_veri_reg;
    ilk_next           = ilk_reg;
    iptal_next         = iptal_reg;
    aclik_sayac_next   = aclik_sayac_reg;
    adres_next         = adres_reg;
    yaz_next           = yaz_reg;
    veri_next          = veri_reg;
    maske_next         = maske_reg;
    getir_gecerli_next = 1'b0;
    getir_veri_next    = getir_veri_reg;
    veri_gecerli_next  = 1'b0;
    veri_okunan_next   = veri_okunan_reg;

    unique case (durum_reg)
      BOSTA: begin
        iptal_next = 1'b0;
        if (veri_istek_i && !getir_oncelik) begin
          durum_next       = ISTEK;
          sahip_veri_next  = 1'b1;
          ilk_next         = 1'b1;
          adres_next       = veri_adres_i;
          yaz_next         = veri_yaz_i;
          veri_next        = veri_yazilan_i;
          maske_next       = veri_maske_i;
          aclik_sayac_next = !getir_istek_i ? 2'd0 :
                             (aclik_sayac_reg == SINIR) ? SINIR : aclik_sayac_reg + 2'd1;
        end else if (getir_uygun) begin
          durum_next       = ISTEK;
          sahip_veri_next  = 1'b0;
          ilk_next         = 1'b1;
          adres_next       = getir_adres_i;
          yaz_next         = 1'b0;
          veri_next        = '0;
          maske_next       = '0;
          aclik_sayac_next = 2'd0;
        end
      end
      ISTEK: begin
        ilk_next = 1'b0;
        if (!sahip_veri_reg && getir_iptal_i) iptal_next = 1'b1;
        if (bel_hazir_i) durum_next = YANIT;
      end
      YANIT: begin
        if (!sahip_veri_reg && getir_iptal_i) iptal_next = 1'b1;
        if (bel_gecerli_i) begin
          durum_next = BOSTA;
          iptal_next = 1'b0;
          if (sahip_veri_reg) begin
            veri_gecerli_next = 1'b1;
            veri_okunan_next  = yaz_reg ? '0 : bel_veri_i;
          end else begin
            // A flush in the completion cycle itself still suppresses delivery.
            getir_veri_next    = bel_veri_i;
            getir_gecerli_next = !(iptal_reg || getir_iptal_i);
          end
        end
      end
      default: durum_next = BOSTA;
    endcase
  end

  assign bel_istek_o     = (durum_reg == ISTEK);
  assign getir_kabul_o   = bel_istek_o && ilk_reg && !sahip_veri_reg;
  assign veri_kabul_o    = bel_istek_o && ilk_reg && sahip_veri_reg;
  assign bel_yaz_o       = yaz_reg;
  assign bel_adres_o     = adres_reg;
  assign bel_veri_o      = veri_reg;
  assign bel_maske_o     = maske_reg;
  assign getir_gecerli_o = getir_gecerli_reg;
  assign getir_veri_o    = getir_veri_reg;
  assign veri_gecerli_o  = veri_gecerli_reg;
  assign veri_okunan_o   = veri_okunan_reg;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus a randomized
// run against a transaction-level model of arbitration, payload and delivery.
module tb_memory_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MW  = DW / 8;
  localparam int LIM = 2;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          getir_istek_i, getir_iptal_i, getir_kabul_o, getir_gecerli_o;
  logic [AW-1:0] getir_adres_i;
  logic [DW-1:0] getir_veri_o;
  logic          veri_istek_i, veri_yaz_i, veri_kabul_o, veri_gecerli_o;
  logic [AW-1:0] veri_adres_i;
  logic [DW-1:0] veri_yazilan_i, veri_okunan_o;
  logic [MW-1:0] veri_maske_i;
  logic          bel_istek_o, bel_yaz_o, bel_hazir_i, bel_gecerli_i;
  logic [AW-1:0] bel_adres_o;
  logic [DW-1:0] bel_veri_o, bel_veri_i;
  logic [MW-1:0] bel_maske_o;

  int checks   = 0;
  int failures = 0;

  memory_arbiter #(.ADRES_W(AW), .VERI_W(DW), .ACLIK_SINIRI(LIM)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .getir_istek_i(getir_istek_i), .getir_adres_i(getir_adres_i), .getir_iptal_i(getir_iptal_i),
    .getir_kabul_o(getir_kabul_o), .getir_gecerli_o(getir_gecerli_o), .getir_veri_o(getir_veri_o),
    .veri_istek_i(veri_istek_i), .veri_yaz_i(veri_yaz_i), .veri_adres_i(veri_adres_i),
    .veri_yazilan_i(veri_yazilan_i), .veri_maske_i(veri_maske_i),
    .veri_kabul_o(veri_kabul_o), .veri_gecerli_o(veri_gecerli_o), .veri_okunan_o(veri_okunan_o),
    .bel_istek_o(bel_istek_o), .bel_yaz_o(bel_yaz_o), .bel_adres_o(bel_adres_o),
    .bel_veri_o(bel_veri_o), .bel_maske_o(bel_maske_o),
    .bel_hazir_i(bel_hazir_i), .bel_gecerli_i(bel_gecerli_i), .bel_veri_i(bel_veri_i)
  );

  always #5 clk_i = ~clk_i;

  wire [137:0] all_out = {getir_kabul_o, getir_gecerli_o, getir_veri_o, veri_kabul_o,
                          veri_gecerli_o, veri_okunan_o, bel_istek_o, bel_yaz_o,
                          bel_adres_o, bel_veri_o, bel_maske_o};

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    getir_istek_i = 0; getir_adres_i = '0; getir_iptal_i = 0;
    veri_istek_i = 0; veri_yaz_i = 0; veri_adres_i = '0; veri_yazilan_i = '0; veri_maske_i = '0;
    bel_hazir_i = 0; bel_gecerli_i = 0; bel_veri_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 0;
    tick();
    tick();
    rst_i = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst_i = 0;
    #1;
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL reset_async outputs=%h required=0", all_out);
    end
    tick();
    tick();
    rst_i = 1;
    tick();
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL reset_idle outputs=%h required=0", all_out);
    end
    $display("test_reset done");
  endtask

  task automatic test_lone_fetch();
    do_reset();
    getir_istek_i = 1; getir_adres_i = 32'h100;
    tick();
    checks++;
    if ({getir_kabul_o, veri_kabul_o} !== 2'b10) begin
      failures++; $display("FAIL fetch_kabul kabul(g,v)=%b required=10", {getir_kabul_o, veri_kabul_o});
    end
    checks++;
    if ({bel_istek_o, bel_yaz_o, bel_adres_o, bel_veri_o, bel_maske_o} !== {1'b1, 1'b0, 32'h100, 32'h0, 4'h0}) begin
      failures++; $display("FAIL fetch_bel istek=%b yaz=%b adr=%h veri=%h maske=%h required 1 0 100 0 0",
                           bel_istek_o, bel_yaz_o, bel_adres_o, bel_veri_o, bel_maske_o);
    end
    getir_istek_i = 0; bel_hazir_i = 1;
    tick();
    checks++;
    if ({bel_istek_o, getir_kabul_o, getir_gecerli_o} !== 3'b000) begin
      failures++; $display("FAIL fetch_yanit istek/kabul/gecerli=%b required=000",
                           {bel_istek_o, getir_kabul_o, getir_gecerli_o});
    end
    bel_hazir_i = 0; bel_gecerli_i = 1; bel_veri_i = 32'h0000_0013;
    tick();
    checks++;
    if ({getir_gecerli_o, getir_veri_o, veri_gecerli_o, veri_kabul_o} !== {1'b1, 32'h13, 1'b0, 1'b0}) begin
      failures++; $display("FAIL fetch_deliver gecerli=%b veri=%h veri_gecerli=%b required 1 00000013 0",
                           getir_gecerli_o, getir_veri_o, veri_gecerli_o);
    end
    bel_gecerli_i = 0;
    tick();
    checks++;
    if (getir_gecerli_o !== 1'b0) begin
      failures++; $display("FAIL fetch_pulse gecerli=%b required=0", getir_gecerli_o);
    end
    $display("test_lone_fetch done");
  endtask

  task automatic test_alternation();
    byte   order[$];
    string exp_order = "VVGVVG";
    do_reset();
    getir_istek_i = 1; veri_istek_i = 1; bel_hazir_i = 1; bel_gecerli_i = 1;
    for (int c = 0; c < 18; c++) begin
      getir_adres_i = $urandom; veri_adres_i = $urandom; bel_veri_i = $urandom;
      tick();
      if (getir_kabul_o === 1'b1) order.push_back("G");
      if (veri_kabul_o === 1'b1)  order.push_back("V");
    end
    checks++;
    if (order.size() != 6) begin
      failures++; $display("FAIL alt_count grants=%0d required=6", order.size());
    end
    for (int i = 0; i < 6 && i < order.size(); i++) begin
      checks++;
      if (order[i] != exp_order[i]) begin
        failures++; $display("FAIL alt_order grant%0d=%c required=%c", i, order[i], exp_order[i]);
      end
    end
    $display("test_alternation done grants=%0d", order.size());
  endtask

  task automatic test_flush();
    do_reset();
    getir_istek_i = 1; getir_adres_i = 32'h40;
    tick();
    checks++;
    if ({getir_kabul_o, bel_adres_o} !== {1'b1, 32'h40}) begin
      failures++; $display("FAIL flush_kabul kabul=%b adr=%h required 1 40", getir_kabul_o, bel_adres_o);
    end
    getir_istek_i = 0; bel_hazir_i = 1;
    tick();
    bel_hazir_i = 0; getir_iptal_i = 1;
    tick();
    getir_iptal_i = 0; bel_gecerli_i = 1; bel_veri_i = 32'hBAD0_BAD0;
    tick();
    checks++;
    if (getir_gecerli_o !== 1'b0) begin
      failures++; $display("FAIL flush_suppress gecerli=%b required=0", getir_gecerli_o);
    end
    bel_gecerli_i = 0; getir_istek_i = 1; getir_adres_i = 32'h200;
    tick();
    checks++;
    if ({getir_kabul_o, bel_adres_o, getir_gecerli_o} !== {1'b1, 32'h200, 1'b0}) begin
      failures++; $display("FAIL flush_next_kabul kabul=%b adr=%h gecerli=%b required 1 200 0",
                           getir_kabul_o, bel_adres_o, getir_gecerli_o);
    end
    getir_istek_i = 0; bel_hazir_i = 1;
    tick();
    bel_hazir_i = 0; bel_gecerli_i = 1; bel_veri_i = 32'h00C0_FFEE;
    tick();
    checks++;
    if ({getir_gecerli_o, getir_veri_o} !== {1'b1, 32'h00C0_FFEE}) begin
      failures++; $display("FAIL flush_next_deliver gecerli=%b veri=%h required 1 00c0ffee",
                           getir_gecerli_o, getir_veri_o);
    end
    bel_gecerli_i = 0;
    $display("test_flush done");
  endtask

  task automatic test_write_stall();
    do_reset();
    veri_istek_i = 1; veri_yaz_i = 1; veri_adres_i = 32'h80;
    veri_yazilan_i = 32'hDEAD_BEEF; veri_maske_i = 4'b0011;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if ({bel_istek_o, bel_yaz_o, bel_adres_o, bel_veri_o, bel_maske_o} !==
          {1'b1, 1'b1, 32'h80, 32'hDEAD_BEEF, 4'b0011}) begin
        failures++; $display("FAIL write_bel cyc%0d istek=%b yaz=%b adr=%h veri=%h maske=%b required 1 1 80 deadbeef 0011",
                             i, bel_istek_o, bel_yaz_o, bel_adres_o, bel_veri_o, bel_maske_o);
      end
      checks++;
      if (veri_kabul_o !== (i == 1)) begin
        failures++; $display("FAIL write_kabul cyc%0d kabul=%b required=%b", i, veri_kabul_o, i == 1);
      end
      if (i == 1) begin
        veri_istek_i = 0; veri_adres_i = $urandom; veri_yazilan_i = $urandom; veri_maske_i = 4'hC;
      end
      bel_hazir_i = (i == 4);
    end
    tick();
    checks++;
    if ({bel_istek_o, veri_gecerli_o} !== 2'b00) begin
      failures++; $display("FAIL write_yanit istek/gecerli=%b required=00", {bel_istek_o, veri_gecerli_o});
    end
    bel_hazir_i = 0; bel_gecerli_i = 1; bel_veri_i = 32'hFFFF_FFFF;
    tick();
    checks++;
    if ({veri_gecerli_o, veri_okunan_o} !== {1'b1, 32'h0}) begin
      failures++; $display("FAIL write_done gecerli=%b okunan=%h required 1 0", veri_gecerli_o, veri_okunan_o);
    end
    bel_gecerli_i = 0;
    tick();
    checks++;
    if (veri_gecerli_o !== 1'b0) begin
      failures++; $display("FAIL write_pulse gecerli=%b required=0", veri_gecerli_o);
    end
    $display("test_write_stall done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    veri_istek_i = 1; veri_yaz_i = 0; veri_adres_i = 32'h300;
    tick();
    checks++;
    if (veri_kabul_o !== 1'b1) begin
      failures++; $display("FAIL rmid_kabul kabul=%b required=1", veri_kabul_o);
    end
    veri_istek_i = 0; bel_hazir_i = 1;
    tick();
    bel_hazir_i = 0;
    #2 rst_i = 0;
    #1;
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL rmid_async outputs=%h required=0", all_out);
    end
    bel_gecerli_i = 1; bel_veri_i = 32'h5555_5555;
    tick();
    tick();
    rst_i = 1; getir_istek_i = 1; getir_adres_i = 32'h444;
    tick();
    checks++;
    if ({getir_kabul_o, veri_gecerli_o, getir_gecerli_o, bel_adres_o} !== {3'b100, 32'h444}) begin
      failures++; $display("FAIL rmid_first_grant kabul=%b veri_gecerli=%b getir_gecerli=%b adr=%h required 1 0 0 444",
                           getir_kabul_o, veri_gecerli_o, getir_gecerli_o, bel_adres_o);
    end
    getir_istek_i = 0;
    tick();
    checks++;
    if ({bel_istek_o, veri_gecerli_o, getir_gecerli_o} !== 3'b100) begin
      failures++; $display("FAIL rmid_late_ack istek/vg/gg=%b required=100",
                           {bel_istek_o, veri_gecerli_o, getir_gecerli_o});
    end
    bel_gecerli_i = 0;
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    int            phase = 0;  // 0 port free, 1 request phase, 2 awaiting response
    bit            own_data = 0, cancel = 0, g_pend = 0, v_pend = 0;
    bit            fetch_ok, starve;
    bit            hist[$];    // per grant: data won while fetch was requesting
    bit            e_gk = 0, e_vk = 0, e_gg = 0, e_vg = 0, e_bi = 0;
    logic [DW-1:0] e_gd = '0, e_vd = '0;
    logic [AW-1:0] m_adr = '0;
    logic          m_yaz = 0;
    logic [DW-1:0] m_wd = '0;
    logic [MW-1:0] m_mask = '0;
    int            n_g = 0, n_v = 0;
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc > 0) begin
        checks++;
        if ({getir_kabul_o, veri_kabul_o, getir_gecerli_o, veri_gecerli_o, bel_istek_o} !==
            {e_gk, e_vk, e_gg, e_vg, e_bi}) begin
          failures++; $display("FAIL rnd_ctl cyc%0d kabul(g,v)/gecerli(g,v)/istek=%b required=%b", cyc,
                               {getir_kabul_o, veri_kabul_o, getir_gecerli_o, veri_gecerli_o, bel_istek_o},
                               {e_gk, e_vk, e_gg, e_vg, e_bi});
        end
        if (e_bi) begin
          checks++;
          if ({bel_yaz_o, bel_adres_o, bel_veri_o, bel_maske_o} !== {m_yaz, m_adr, m_wd, m_mask}) begin
            failures++; $display("FAIL rnd_payload cyc%0d yaz=%b adr=%h veri=%h maske=%h required %b %h %h %h", cyc,
                                 bel_yaz_o, bel_adres_o, bel_veri_o, bel_maske_o, m_yaz, m_adr, m_wd, m_mask);
          end
        end
        if (e_gg) begin
          checks++;
          if (getir_veri_o !== e_gd) begin
            failures++; $display("FAIL rnd_fetch_data cyc%0d veri=%h required=%h", cyc, getir_veri_o, e_gd);
          end
        end
        if (e_vg) begin
          checks++;
          if (veri_okunan_o !== e_vd) begin
            failures++; $display("FAIL rnd_data_read cyc%0d okunan=%h required=%h", cyc, veri_okunan_o, e_vd);
          end
        end
      end
      if (e_gk) g_pend = 0;
      if (e_vk) v_pend = 0;
      if (!g_pend && $urandom_range(0, 2) == 0) begin
        g_pend = 1; getir_adres_i = $urandom & 32'hFFFF_FFFC;
      end
      if (!v_pend && $urandom_range(0, 2) == 0) begin
        v_pend = 1; veri_yaz_i = $urandom_range(0, 1) == 1; veri_adres_i = $urandom;
        veri_yazilan_i = $urandom; veri_maske_i = 4'($urandom_range(0, 15));
      end
      getir_istek_i = g_pend;
      veri_istek_i  = v_pend;
      getir_iptal_i = ($urandom_range(0, 9) == 0);
      bel_hazir_i   = ($urandom_range(0, 2) != 0);
      bel_gecerli_i = ($urandom_range(0, 2) != 0);
      bel_veri_i    = $urandom;

      e_gk = 0; e_vk = 0; e_gg = 0; e_vg = 0;
      if (phase != 0 && !own_data && getir_iptal_i) cancel = 1;
      case (phase)
        0: begin
          cancel   = 0;
          fetch_ok = g_pend && !getir_iptal_i;
          starve   = hist.size() >= LIM;
          for (int k = 0; k < LIM; k++)
            if (starve && !hist[hist.size() - 1 - k]) starve = 0;
          if (v_pend && !(fetch_ok && starve)) begin
            own_data = 1; e_vk = 1; phase = 1; n_v++;
            hist.push_back(g_pend);
            m_adr = veri_adres_i; m_yaz = veri_yaz_i; m_wd = veri_yazilan_i; m_mask = veri_maske_i;
          end else if (fetch_ok) begin
            own_data = 0; e_gk = 1; phase = 1; n_g++;
            hist.push_back(1'b0);
            m_adr = getir_adres_i; m_yaz = 0; m_wd = '0; m_mask = '0;
          end
        end
        1: if (bel_hazir_i) phase = 2;
        default: if (bel_gecerli_i) begin
          phase = 0;
          if (own_data) begin
            e_vg = 1; e_vd = m_yaz ? '0 : bel_veri_i;
          end else if (!cancel) begin
            e_gg = 1; e_gd = bel_veri_i;
          end
        end
      endcase
      e_bi = (phase == 1);
      tick();
    end
    idle_inputs();
    $display("test_random done fetch_grants=%0d data_grants=%0d", n_g, n_v);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_lone_fetch();
    test_alternation();
    test_flush();
    test_write_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter ADRES_W, default 32, address width of all ports.
REQ-002 Parameter VERI_W, default 32, data width of all ports.
REQ-003 Parameter ACLIK_SINIRI, default 2, maximum consecutive data grants while fetch waits (1..3).
REQ-004 clk_i  in  1  single clock, all state on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-low.
REQ-006 getir_istek_i  in  1  fetch read request, held with address until getir_kabul_o.
REQ-007 getir_adres_i  in  ADRES_W  fetch program counter.
REQ-008 getir_iptal_i  in  1  fetch flush (misprediction); cancels delivery of in-flight fetch.
REQ-009 getir_kabul_o  out  1  one-cycle pulse: fetch request latched.
REQ-010 getir_gecerli_o / getir_veri_o  out  1 / VERI_W  one-cycle instruction delivery.
REQ-011 veri_istek_i, veri_yaz_i  in  1, 1  data request, write when 1; held with payload until veri_kabul_o.
REQ-012 veri_adres_i, veri_yazilan_i, veri_maske_i  in  ADRES_W, VERI_W, VERI_W/8  data address, store data, byte mask.
REQ-013 veri_kabul_o  out  1  one-cycle pulse: data request latched.
REQ-014 veri_gecerli_o / veri_okunan_o  out  1 / VERI_W  one-cycle completion; read data (0 on writes).
REQ-015 bel_istek_o, bel_yaz_o, bel_adres_o, bel_veri_o, bel_maske_o  out  shared memory request channel.
REQ-016 bel_hazir_i  in  1  memory accepts request when bel_istek_o and bel_hazir_i both high.
REQ-017 bel_gecerli_i / bel_veri_i  in  1 / VERI_W  memory response (read data or write ack).

Function
REQ-018 FSM states BOSTA, ISTEK, YANIT; exactly one transaction outstanding on the memory port.
REQ-019 BOSTA: if any eligible request, latch owner and payload, go ISTEK; else stay.
REQ-020 Arbitration: data wins over fetch, except fetch wins when aclik_sayac == ACLIK_SINIRI and getir_istek_i high.
REQ-021 aclik_sayac: +1 on data grant while getir_istek_i high; cleared on fetch grant or on data grant with fetch idle; saturates at ACLIK_SINIRI.
REQ-022 Fetch is ineligible in a BOSTA cycle where getir_iptal_i is high.
REQ-023 ISTEK: bel_istek_o=1 with latched payload, stable every cycle; kabul_o of owner high only in first ISTEK cycle; on bel_hazir_i go YANIT.
REQ-024 bel_yaz_o/bel_veri_o/bel_maske_o driven from latched data payload; zero for fetch transactions.
REQ-025 YANIT: bel_istek_o=0; on bel_gecerli_i capture bel_veri_i, go BOSTA; owner gecerli_o high the following cycle only.
REQ-026 Latency: request seen in BOSTA cycle N, bel_hazir_i in N+1, bel_gecerli_i in N+2 -> gecerli_o in N+3; new grant possible in N+3.
REQ-027 getir_iptal_i while fetch owns ISTEK or YANIT sets iptal flag; transaction completes on memory but getir_gecerli_o stays 0; flag cleared entering BOSTA.
REQ-028 getir_iptal_i has no effect on a data-owned transaction.
REQ-029 bel_gecerli_i outside YANIT ignored; bel_hazir_i outside ISTEK ignored.
REQ-030 getir_veri_o/veri_okunan_o hold last captured value when gecerli low; only gecerli is meaningful.

Reset
REQ-031 rst_i low: immediately state BOSTA, all outputs 0, aclik_sayac 0, iptal flag 0, latched payload 0.
REQ-032 Reset mid-transaction abandons it; no gecerli_o pulse follows release, late bel_gecerli_i ignored.
REQ-033 First grant possible in first rising edge after rst_i returns high.

Verification
REQ-034 Lone fetch 0x100, bel_hazir_i immediate, bel_gecerli_i next cycle with 0x00000013 -> getir_kabul_o cycle 1, getir_gecerli_o cycle 3 with 0x00000013, veri outputs silent.
REQ-035 Both requesters held continuously, ACLIK_SINIRI=2 -> grant order V,V,G,V,V,G; aclik_sayac 1,2,0 repeating.
REQ-036 Fetch 0x40 with getir_iptal_i pulsed in YANIT -> no getir_gecerli_o; following fetch 0x200 delivered with its own data.
REQ-037 Write addr 0x80, data 0xDEADBEEF, mask 4'b0011, bel_hazir_i low 3 cycles -> bel_* stable 4 ISTEK cycles, veri_gecerli_o once after ack, veri_okunan_o 0.
REQ-038 rst_i low during YANIT of data read -> outputs 0 asynchronously; bel_gecerli_i after release produces no veri_gecerli_o.
